// File: rtl/fpu_rf_pkg.sv
// fpu_rf_pkg: shared constants and types for the FPU register file.
// Default geometry is 64 registers of 32 bits; freg_t / fraddr_t give
// the matching register-value and register-address types.
package fpu_rf_pkg;
    localparam int FPU_XLEN  = 32;
    localparam int FPU_NREGS = 64;
    localparam int FPU_AW    = $clog2(FPU_NREGS);

    typedef logic [FPU_XLEN-1:0] freg_t;
    typedef logic [FPU_AW-1:0]   fraddr_t;
endpackage

// File: rtl/fpu_scoreboard.sv
// fpu_scoreboard: per-register busy bits for in-flight FPU results.
// Ports:
//   clk, rst        clock (rising edge), async active-low reset
//   rd_addr/rd_busy read addresses in, busy flag per read port out (comb)
//   wr_en/wr_addr   writeback ports; a write clears the target's busy bit
//   iss_en/iss_addr issue request; sets the destination's busy bit
//   iss_stall       issue refused because the destination is already busy
module fpu_scoreboard
    import fpu_rf_pkg::*;
#(
    parameter int NREGS    = FPU_NREGS,
    parameter int NRD      = 3,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]    rd_busy,
    input  logic [NWR-1:0]    wr_en,
    input  logic [NWR*AW-1:0] wr_addr,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic              iss_stall
);
    logic [NREGS-1:0] r_busy;
    logic [NREGS-1:0] w_busy_nxt;

    // Stall looks only at registered busy, so a writeback landing this
    // cycle does not let a WAW issue through early.
    assign iss_stall = iss_en & r_busy[iss_addr];

    // Clears first, then the issue set, so a new owner wins over a
    // writeback to the same register in the same cycle.
    always_comb begin
        w_busy_nxt = r_busy;
        for (int p = 0; p < NWR; p++)
            if (wr_en[p]) w_busy_nxt[wr_addr[p*AW +: AW]] = 1'b0;
        if (iss_en && !iss_stall && !(ZERO_REG != 0 && iss_addr == '0))
            w_busy_nxt[iss_addr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) r_busy <= '0;
        else      r_busy <= w_busy_nxt;

    // A register being written back this cycle is reported not busy.
    always_comb begin
        rd_busy = '0;
        for (int r = 0; r < NRD; r++) begin
            logic [AW-1:0] a;
            logic          hit;
            a   = rd_addr[r*AW +: AW];
            hit = 1'b0;
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && wr_addr[p*AW +: AW] == a) hit = 1'b1;
            rd_busy[r] = r_busy[a] & ~hit;
        end
    end
endmodule

// File: rtl/fpu_regfile_sb.sv
// fpu_regfile_sb: multi-port FPU register file with write bypass and busy scoreboard.
// Ports:
//   clk, rst        clock (rising edge), async active-low reset
//   rd_addr         NRD packed read addresses
//   rd_data         NRD packed read values (comb, bypassed from writes)
//   rd_busy         NRD busy flags for the read addresses (comb)
//   wr_en/wr_addr/wr_data  NWR writeback ports, highest index wins
//   iss_en/iss_addr issue request marking a destination busy
//   iss_stall       issue refused (WAW on a busy destination)
module fpu_regfile_sb
    import fpu_rf_pkg::*;
#(
    parameter int XLEN     = FPU_XLEN,
    parameter int NREGS    = FPU_NREGS,
    parameter int NRD      = 3,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    output logic                iss_stall
);
    logic [XLEN-1:0] r_regs [NREGS];

    fpu_scoreboard #(
        .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(ZERO_REG)
    ) u_sb (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(iss_stall)
    );

    // Later ports overwrite earlier ones in the loop: highest index wins.
    always_ff @(posedge clk or negedge rst)
        if (!rst)
            r_regs <= '{default: '0};
        else
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && !(ZERO_REG != 0 && wr_addr[p*AW +: AW] == '0))
                    r_regs[wr_addr[p*AW +: AW]] <= wr_data[p*XLEN +: XLEN];

    // Hard-wired zero overrides the bypass, so writes to r0 never leak out.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < NRD; r++) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] d;
            a = rd_addr[r*AW +: AW];
            d = r_regs[a];
            for (int p = 0; p < NWR; p++)
                if (wr_en[p] && wr_addr[p*AW +: AW] == a) d = wr_data[p*XLEN +: XLEN];
            rd_data[r*XLEN +: XLEN] = (ZERO_REG != 0 && a == '0) ? '0 : d;
        end
    end
endmodule

// File: tb/tb_fpu_regfile_sb.sv
// tb_fpu_regfile_sb: directed vector bench for fpu_regfile_sb (ZERO_REG=1 and ZERO_REG=0 instances).
module tb_fpu_regfile_sb;
    import fpu_rf_pkg::*;

    localparam int XLEN = 32, NREGS = 64, AW = 6, NRD = 3, NWR = 2;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NRD*AW-1:0]   rd_addr = '0;
    logic [NRD*XLEN-1:0] rd_data, rd_data_z;
    logic [NRD-1:0]      rd_busy, rd_busy_z;
    logic [NWR-1:0]      wr_en = '0;
    logic [NWR*AW-1:0]   wr_addr = '0;
    logic [NWR*XLEN-1:0] wr_data = '0;
    logic                iss_en = 1'b0;
    logic [AW-1:0]       iss_addr = '0;
    logic                iss_stall, iss_stall_z;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fpu_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(iss_stall)
    );

    fpu_regfile_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .ZERO_REG(0)) dut_z (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_z), .rd_busy(rd_busy_z),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_stall(iss_stall_z)
    );

    typedef struct {
        logic [1:0] we;
        fraddr_t    wa0;
        freg_t      wd0;
        fraddr_t    wa1;
        freg_t      wd1;
        logic       ie;
        fraddr_t    ia;
        fraddr_t    ra;
        freg_t      ed;
        logic       eb;
        logic       es;
        freg_t      zd;
        logic       zb;
        logic       zs;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0; iss_en = 1'b0; iss_addr = '0;
    endtask

    task automatic scan_zero(input string tag);
        for (int a = 0; a < NREGS; a++) begin
            rd_addr = {6'(a + 2), 6'(a + 1), 6'(a)};
            #1;
            for (int r = 0; r < NRD; r++) begin
                check({tag, "_data"}, a, rd_data[r*XLEN +: XLEN], 32'h0);
                check({tag, "_busy"}, a, 32'(rd_busy[r]), 32'h0);
                check({tag, "_zdata"}, a, rd_data_z[r*XLEN +: XLEN], 32'h0);
                check({tag, "_zbusy"}, a, 32'(rd_busy_z[r]), 32'h0);
            end
        end
    endtask

    initial begin
        //          we  wa0    wd0           wa1    wd1           ie  ia     ra     ed            eb  es  zd            zb  zs
        vecs[0]  = '{2'b01, 6'd5,  32'h3F800000, 6'd0,  32'h0,        0, 6'd0,  6'd5,  32'h3F800000, 0, 0, 32'h3F800000, 0, 0};
        vecs[1]  = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,        0, 6'd0,  6'd5,  32'h3F800000, 0, 0, 32'h3F800000, 0, 0};
        vecs[2]  = '{2'b11, 6'd7,  32'h11111111, 6'd7,  32'h22222222, 0, 6'd0,  6'd7,  32'h22222222, 0, 0, 32'h22222222, 0, 0};
        vecs[3]  = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,        0, 6'd0,  6'd7,  32'h22222222, 0, 0, 32'h22222222, 0, 0};
        vecs[4]  = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,        1, 6'd9,  6'd9,  32'h0,        0, 0, 32'h0,        0, 0};
        vecs[5]  = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,        1, 6'd9,  6'd9,  32'h0,        1, 1, 32'h0,        1, 1};
        vecs[6]  = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,        0, 6'd0,  6'd9,  32'h0,        1, 0, 32'h0,        1, 0};
        vecs[7]  = '{2'b01, 6'd9,  32'hAAAA5555, 6'd0,  32'h0,        1, 6'd9,  6'd9,  32'hAAAA5555, 0, 1, 32'hAAAA5555, 0, 1};
        vecs[8]  = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,        0, 6'd0,  6'd9,  32'hAAAA5555, 0, 0, 32'hAAAA5555, 0, 0};
        vecs[9]  = '{2'b01, 6'd12, 32'h12345678, 6'd0,  32'h0,        1, 6'd12, 6'd12, 32'h12345678, 0, 0, 32'h12345678, 0, 0};
        vecs[10] = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,        0, 6'd0,  6'd12, 32'h12345678, 1, 0, 32'h12345678, 1, 0};
        vecs[11] = '{2'b01, 6'd0,  32'hDEADBEEF, 6'd0,  32'h0,        0, 6'd0,  6'd0,  32'h0,        0, 0, 32'hDEADBEEF, 0, 0};
        vecs[12] = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,        1, 6'd0,  6'd0,  32'h0,        0, 0, 32'hDEADBEEF, 0, 0};
        vecs[13] = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,        1, 6'd0,  6'd0,  32'h0,        0, 0, 32'hDEADBEEF, 1, 1};
        vecs[14] = '{2'b10, 6'd0,  32'h0,        6'd20, 32'hCAFEF00D, 0, 6'd0,  6'd20, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0, 0};
        vecs[15] = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,        0, 6'd0,  6'd20, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0, 0};
        vecs[16] = '{2'b10, 6'd0,  32'h0,        6'd12, 32'h0BADF00D, 0, 6'd0,  6'd12, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 0, 0};
        vecs[17] = '{2'b00, 6'd0,  32'h0,        6'd0,  32'h0,        0, 6'd0,  6'd12, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 0, 0};

        // Reset held through a few edges with random traffic on every input.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_en = NWR'($urandom); wr_addr = NWR*AW'($urandom);
            wr_data = {$urandom, $urandom}; iss_en = 1'($urandom);
            iss_addr = AW'($urandom); rd_addr = NRD*AW'($urandom);
        end
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        check("rst_stall", 0, 32'(iss_stall), 32'h0);
        scan_zero("rst");

        foreach (vecs[i]) begin
            @(negedge clk);
            wr_en    = vecs[i].we;
            wr_addr  = {vecs[i].wa1, vecs[i].wa0};
            wr_data  = {vecs[i].wd1, vecs[i].wd0};
            iss_en   = vecs[i].ie;
            iss_addr = vecs[i].ia;
            rd_addr  = {vecs[i].ra, vecs[i].ra, vecs[i].ra};
            #2;
            for (int r = 0; r < NRD; r++) begin
                check("data", i, rd_data[r*XLEN +: XLEN], vecs[i].ed);
                check("busy", i, 32'(rd_busy[r]), 32'(vecs[i].eb));
                check("zdata", i, rd_data_z[r*XLEN +: XLEN], vecs[i].zd);
                check("zbusy", i, 32'(rd_busy_z[r]), 32'(vecs[i].zb));
            end
            check("stall", i, 32'(iss_stall), 32'(vecs[i].es));
            check("zstall", i, 32'(iss_stall_z), 32'(vecs[i].zs));
        end

        // Distinct addresses on each read port at once.
        @(negedge clk);
        idle();
        rd_addr = {6'd7, 6'd20, 6'd5};
        #1;
        check("mix_p0", 0, rd_data[0 +: XLEN], 32'h3F800000);
        check("mix_p1", 1, rd_data[XLEN +: XLEN], 32'hCAFEF00D);
        check("mix_p2", 2, rd_data[2*XLEN +: XLEN], 32'h22222222);

        // Mid-operation asynchronous reset with a writeback pending.
        iss_en = 1'b1; iss_addr = 6'd30;
        @(negedge clk);
        idle();
        rd_addr = {6'd30, 6'd30, 6'd30};
        #1;
        check("pre_rst_busy", 30, 32'(rd_busy[0]), 32'h1);
        wr_en = 2'b01; wr_addr = {6'd0, 6'd30}; wr_data = {32'h0, 32'h0000FFFF};
        #1;
        rst = 1'b0;
        #1;
        wr_en = '0;
        rd_addr = {6'd30, 6'd7, 6'd5};
        #1;
        for (int r = 0; r < NRD; r++) begin
            check("async_data", r, rd_data[r*XLEN +: XLEN], 32'h0);
            check("async_busy", r, 32'(rd_busy[r]), 32'h0);
        end
        wr_en = 2'b01;
        @(negedge clk);
        idle();
        rst = 1'b1;
        #1;
        scan_zero("mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
